// File: rtl/io_bus_master_pkg.sv
// Shared encodings for the peripheral I/O bus masters (core and DMA side).
package io_bus_master_pkg;

  typedef enum logic [1:0] {
    IOM_IDLE   = 2'd0,
    IOM_ACCESS = 2'd1,
    IOM_ACK    = 2'd2,
    IOM_RESP   = 2'd3
  } iom_state_e;

  localparam logic [1:0] IO_SIZE_B = 2'd0;
  localparam logic [1:0] IO_SIZE_H = 2'd1;
  localparam logic [1:0] IO_SIZE_W = 2'd2;

  localparam int unsigned IO_TIMEOUT = 1023;

endpackage

// File: rtl/io_bus_master_req_check.sv
// Size/alignment legality check for an I/O bus request; purely combinational.
module io_req_check
  import io_bus_master_pkg::*;
(
  input  logic [1:0] addr_lsb_i,
  input  logic [1:0] size_i,
  output logic       illegal_o
);

  assign illegal_o = (size_i == 2'd3) ||
                     ((size_i == IO_SIZE_H) && addr_lsb_i[0]) ||
                     ((size_i == IO_SIZE_W) && (addr_lsb_i != 2'b00));

endmodule

// File: rtl/io_bus_master.sv
// Core-side master for the peripheral I/O bus: request check, strobe protocol,
// read acknowledge and a watchdog that converts a hung peripheral into an error.
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = IO_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_byte_size,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] io_addr,
  output logic            io_read,
  output logic            io_write,
  output logic [XLEN-1:0] io_wdata,
  output logic [1:0]      io_byte_size,
  output logic            read_ready,
  input  logic [XLEN-1:0] io_rdata,
  input  logic            io_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  iom_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] io_addr_q, io_addr_d;
  logic            io_read_q, io_read_d;
  logic            io_write_q, io_write_d;
  logic [XLEN-1:0] io_wdata_q, io_wdata_d;
  logic [1:0]      io_byte_size_q, io_byte_size_d;
  logic            read_ready_q, read_ready_d;
  logic            illegal;
  logic            wd_expired;

  io_req_check u_req_check (
    .addr_lsb_i (req_addr[1:0]),
    .size_i     (req_byte_size),
    .illegal_o  (illegal)
  );

  // cnt_q can sit one past CNT_LAST when io_ready won the race on the last ACCESS cycle
  assign wd_expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    write_d        = write_q;
    req_ready_d    = req_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    io_addr_d      = io_addr_q;
    io_read_d      = io_read_q;
    io_write_d     = io_write_q;
    io_wdata_d     = io_wdata_q;
    io_byte_size_d = io_byte_size_q;
    read_ready_d   = read_ready_q;

    case (state_q)
      IOM_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d    = 1'b0;
          write_d        = req_write;
          io_addr_d      = req_addr;
          io_wdata_d     = req_wdata;
          io_byte_size_d = req_byte_size;
          rsp_rdata_d    = '0;
          cnt_d          = '0;
          if (illegal) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = IOM_RESP;
          end else begin
            rsp_err_d  = 1'b0;
            io_read_d  = !req_write;
            io_write_d = req_write;
            state_d    = IOM_ACCESS;
          end
        end
      end

      IOM_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (io_ready) begin
          io_read_d  = 1'b0;
          io_write_d = 1'b0;
          if (write_q) begin
            rsp_valid_d = 1'b1;
            state_d     = IOM_RESP;
          end else begin
            rsp_rdata_d  = io_rdata;
            read_ready_d = 1'b1;
            state_d      = IOM_ACK;
          end
        end else if (wd_expired) begin
          io_read_d   = 1'b0;
          io_write_d  = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = IOM_RESP;
        end
      end

      IOM_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (!io_ready) begin
          read_ready_d = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = IOM_RESP;
        end else if (wd_expired) begin
          read_ready_d = 1'b0;
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          state_d      = IOM_RESP;
        end
      end

      IOM_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IOM_IDLE;
        end
      end

      default: state_d = IOM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IOM_IDLE;
      cnt_q          <= '0;
      write_q        <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      io_addr_q      <= '0;
      io_read_q      <= 1'b0;
      io_write_q     <= 1'b0;
      io_wdata_q     <= '0;
      io_byte_size_q <= '0;
      read_ready_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      write_q        <= write_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
      io_addr_q      <= io_addr_d;
      io_read_q      <= io_read_d;
      io_write_q     <= io_write_d;
      io_wdata_q     <= io_wdata_d;
      io_byte_size_q <= io_byte_size_d;
      read_ready_q   <= read_ready_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign io_addr      = io_addr_q;
  assign io_read      = io_read_q;
  assign io_write     = io_write_q;
  assign io_wdata     = io_wdata_q;
  assign io_byte_size = io_byte_size_q;
  assign read_ready   = read_ready_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master with a registered peripheral model.
module tb_io_bus_master;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_byte_size = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] io_addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] io_wdata;
  logic [1:0]  io_byte_size;
  logic        read_ready;
  logic [31:0] periph_data = '0;
  logic        io_ready;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  int   rr_rise = 0;
  logic rr_prev = 1'b0;
  int   strobe_cycles = 0;
  logic hang = 1'b0;
  int   periph_delay = 2;
  int   pcnt = 0;

  io_bus_master #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_byte_size (req_byte_size),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .io_addr       (io_addr),
    .io_read       (io_read),
    .io_write      (io_write),
    .io_wdata      (io_wdata),
    .io_byte_size  (io_byte_size),
    .read_ready    (read_ready),
    .io_rdata      (periph_data),
    .io_ready      (io_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Registered peripheral: io_ready after periph_delay strobe cycles, released
  // once the master takes the data (load) or drops the strobe (store).
  always @(posedge clk) begin
    if (!rst_n) begin
      io_ready <= 1'b0;
      pcnt     <= 0;
    end else if (io_ready) begin
      if (read_ready || (!io_read && !io_write)) io_ready <= 1'b0;
    end else if ((io_read || io_write) && !hang) begin
      if (pcnt + 1 >= periph_delay) begin
        io_ready <= 1'b1;
        pcnt     <= 0;
      end else begin
        pcnt <= pcnt + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (io_read && io_write) check("strobe_exclusive", 32'd1, 32'd0);
      if (io_read || io_write) strobe_cycles++;
      if (read_ready && !rr_prev) rr_rise++;
      rr_prev = read_ready;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic [31:0] er, input logic ee);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    req_write     = w;
    req_addr      = a;
    req_wdata     = d;
    req_byte_size = s;
    req_valid     = 1'b1;
    e.err   = ee;
    e.rdata = er;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("response_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    #2 rst_n = 1'b0;
    #10;
    check("rst_ctrl", {24'd0, req_ready, rsp_valid, rsp_err, io_read, io_write, read_ready, io_byte_size}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_io_addr", io_addr, 32'd0);
    check("rst_io_wdata", io_wdata, 32'd0);
    #10 rst_n = 1'b1;
    #2 check("req_ready_pre_edge", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("req_ready_post_rst", {31'd0, req_ready}, 32'd1);

    // Word load
    periph_data = 32'hDEADBEEF;
    rr_rise = 0;
    issue(1'b0, 32'h1000_0000, 32'h0, 2'd2, 32'hDEADBEEF, 1'b0);
    check("load_io_read", {30'd0, io_read, io_write}, 32'd2);
    check("load_io_addr", io_addr, 32'h1000_0000);
    check("load_req_ready_busy", {31'd0, req_ready}, 32'd0);
    wait_idle();
    check("load_rr_pulses", rr_rise, 32'd1);

    // Byte store
    rr_rise = 0;
    issue(1'b1, 32'h1000_0003, 32'h55, 2'd0, 32'h0, 1'b0);
    check("store_strobes", {30'd0, io_read, io_write}, 32'd1);
    check("store_size", {30'd0, io_byte_size}, 32'd0);
    check("store_wdata", io_wdata, 32'h55);
    check("store_addr", io_addr, 32'h1000_0003);
    wait_idle();
    check("store_rr_pulses", rr_rise, 32'd0);

    // Legal half load and word store
    periph_data = 32'hCAFE_0042;
    issue(1'b0, 32'h1000_0002, 32'h0, 2'd1, 32'hCAFE_0042, 1'b0);
    wait_idle();
    issue(1'b1, 32'h1000_0004, 32'h1234_5678, 2'd2, 32'h0, 1'b0);
    wait_idle();

    // Misaligned and illegal sizes: error at N+1, no strobes
    strobe_cycles = 0;
    issue(1'b0, 32'h1000_0002, 32'h0, 2'd2, 32'h0, 1'b1);
    check("mis_word_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    wait_idle();
    issue(1'b1, 32'h1000_0001, 32'hAA, 2'd1, 32'h0, 1'b1);
    check("mis_half_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    wait_idle();
    issue(1'b0, 32'h1000_0000, 32'h0, 2'd3, 32'h0, 1'b1);
    check("size3_rsp", {30'd0, rsp_valid, rsp_err}, 32'd3);
    wait_idle();
    check("err_no_strobe", strobe_cycles, 32'd0);

    // Timeout: peripheral never answers
    hang = 1'b1;
    strobe_cycles = 0;
    issue(1'b0, 32'h2000_0000, 32'h0, 2'd2, 32'h0, 1'b1);
    wait_idle();
    check("timeout_strobe_cycles", strobe_cycles, 32'd8);
    hang = 1'b0;
    periph_data = 32'h0BAD_F00D;
    issue(1'b0, 32'h2000_0004, 32'h0, 2'd2, 32'h0BAD_F00D, 1'b0);
    wait_idle();

    // Backpressure on the response channel
    rsp_ready = 1'b0;
    periph_data = 32'h1357_9BDF;
    issue(1'b0, 32'h3000_0000, 32'h0, 2'd2, 32'h1357_9BDF, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {29'd0, rsp_valid, rsp_err, req_ready}, 32'd4);
      check("bp_rdata", rsp_rdata, 32'h1357_9BDF);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
    wait_idle();

    // Reset in the middle of ACCESS
    hang = 1'b1;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2, 32'h0, 1'b0);
    check("mid_io_read", {31'd0, io_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", {24'd0, req_ready, rsp_valid, rsp_err, io_read, io_write, read_ready, io_byte_size}, 32'd0);
    check("arst_io_addr", io_addr, 32'd0);
    exp_q.delete();
    hang = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    periph_data = 32'h600D_CAFE;
    rr_rise = 0;
    issue(1'b0, 32'h4000_0000, 32'h0, 2'd2, 32'h600D_CAFE, 1'b0);
    wait_idle();
    check("post_rst_rr_pulses", rr_rise, 32'd1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
